fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Downstream consumer of the box-animation FSM: accepts plot requests (x, y, colour, plot) and turns them into linear frame-buffer writes (addr, data, wren) for a 160x120 video memory.
- Adds a valid/ready handshake, bounds checking with a dropped-pixel counter, and a hardware clear-screen sweep.
- Drawing FSMs then never need to emit 19200 clear pixels themselves.

Parameters:
- H_RES, 160, active columns.
- V_RES, 120, active rows.
- COLOUR_W, 3, colour bits per pixel.
- ADDR_W, 15, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- CLEAR_COLOUR, 3'b000, value written during a clear sweep.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset_n  in  1  synchronous, active-low reset.
- x_in  in  8  pixel column.
- y_in  in  7  pixel row.
- colour_in  in  COLOUR_W  pixel colour.
- plot_in  in  1  request valid.
- ready_out  out  1  block can accept a request this cycle.
- clear_req  in  1  start a clear sweep (level sampled in IDLE).
- busy  out  1  clear sweep in progress.
- fb_addr  out  ADDR_W  frame-buffer write address.
- fb_data  out  COLOUR_W  frame-buffer write data.
- fb_wren  out  1  frame-buffer write enable.
- drop_cnt  out  8  count of out-of-range requests, saturating.

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset values: state=IDLE; fb_addr=0, fb_data=0, fb_wren=0, busy=0, drop_cnt=0, internal clear counter=0.
- States:
  - IDLE: accepts plots.
  - CLEAR: sweeps memory.
- ready_out = (state==IDLE) && !clear_req. This is combinational; clear_req has priority over a simultaneous plot_in. In that case the plot is not accepted and upstream must hold it.
- Acceptance: a request is accepted at an edge where plot_in && ready_out.
- In-range accepted request (x_in < H_RES and y_in < V_RES):
  - One cycle later, for exactly one cycle: fb_wren=1, fb_addr=y_in*160+x_in, fb_data=colour_in.
  - Address arithmetic: (y<<7)+(y<<5)+x, computed at ADDR_W bits with no truncation for legal coordinates.
  - Throughput is one pixel per cycle; back-to-back accepts give back-to-back writes.
- Out-of-range accepted request: no write (fb_wren=0 the following cycle); drop_cnt increments, saturating at 255.
- Clear sweep:
  - clear_req high in IDLE at edge T: enter CLEAR.
  - Cycles T+1..T+19200: fb_wren=1, fb_data=CLEAR_COLOUR, fb_addr=0,1,...,19199 (one per cycle).
  - busy=1 and ready_out=0 for cycles T+1..T+19200.
  - At the edge ending cycle T+19200 (clear counter==H_RES*V_RES-1): return to IDLE, busy=0, fb_wren=0, counter cleared.
  - clear_req asserted during CLEAR is ignored. clear_req still high on return to IDLE starts a new sweep.
- Port exclusivity: a plot write issued in cycle T and a clear write cannot collide. ready_out is low whenever clear_req is high, so no plot is accepted in a clear-start cycle.
- Idle outputs: when no write is issued, fb_wren=0; fb_addr and fb_data hold their last values.
- Reset mid-clear: sweep abandoned immediately; all outputs take reset values the next cycle. drop_cnt is also cleared.

Optional Feature:
- Macro FB_COORD_WRAP_EN.
- Defined: out-of-range coordinates wrap instead of being dropped.
  - x >= H_RES uses x-H_RES.
  - y >= V_RES uses y-V_RES.
  - The write is issued normally.
  - drop_cnt is held at 0.
- Undefined: drop-and-count behaviour as specified above.

Test Plan:
- Reset, then plot (x=3, y=2, colour=5) accepted at edge T -> at T+1 fb_wren=1, fb_addr=323, fb_data=5; at T+2 fb_wren=0.
- Four back-to-back plots (0,0), (159,0), (0,119), (159,119) -> consecutive writes to addr 0, 159, 19040, 19199.
- Plot (x=160, y=5), then (x=10, y=120) -> no writes, drop_cnt=2. Also force 300 bad plots -> drop_cnt=255. With FB_COORD_WRAP_EN: the first two give writes to 800 and 10, drop_cnt=0.
- clear_req pulse at T -> 19200 consecutive writes of 0 to addr 0..19199, busy high for exactly 19200 cycles, ready_out low throughout; a plot_in held during the sweep is accepted on the first IDLE cycle.
- clear_req and plot_in both high in IDLE -> ready_out=0, the plot is not accepted, the sweep starts, and the held plot is written after the sweep.
- reset_n low at sweep address 5000 -> next cycle fb_wren=0, busy=0, ready_out=1, and no further clear writes occur.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: turns (x, y, colour, plot) requests into linear
// frame-buffer writes for a 160x120 memory, with a hardware clear sweep.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   x_in, y_in          pixel column / row
//   colour_in           pixel colour
//   plot_in, ready_out  request valid / block can accept this cycle
//   clear_req           start a clear sweep (level, sampled in IDLE)
//   busy                clear sweep in progress
//   fb_addr, fb_data    frame-buffer write address / data
//   fb_wren             frame-buffer write enable
//   drop_cnt            saturating count of out-of-range requests
//
// Build option: define FB_COORD_WRAP_EN to wrap out-of-range coordinates
// (x-H_RES, y-V_RES) instead of dropping them; drop_cnt then stays 0.
module fb_pixel_writer #(
    parameter int                     H_RES        = 160,
    parameter int                     V_RES        = 120,
    parameter int                     COLOUR_W     = 3,
    parameter int                     ADDR_W       = 15,
    parameter logic [COLOUR_W-1:0]    CLEAR_COLOUR = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          x_in,
    input  logic [6:0]          y_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                plot_in,
    output logic                ready_out,
    input  logic                clear_req,
    output logic                busy,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOUR_W-1:0] fb_data,
    output logic                fb_wren,
    output logic [7:0]          drop_cnt
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [7:0]        H_LIM    = 8'(H_RES);
    localparam logic [6:0]        V_LIM    = 7'(V_RES);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [ADDR_W-1:0]   nxt_cnt;
    logic [ADDR_W-1:0]   pix_addr;
    logic [ADDR_W-1:0]   x_ext;
    logic [ADDR_W-1:0]   y_ext;
    logic [7:0]          x_eff;
    logic [6:0]          y_eff;
    logic                write_ok;
    logic                accept;

    // A pending clear always wins over a simultaneous plot.
    assign ready_out = (state == IDLE) && !clear_req;
    assign accept    = plot_in && ready_out;

    always_comb begin
        x_eff = x_in;
        y_eff = y_in;
`ifdef FB_COORD_WRAP_EN
        if (x_in >= H_LIM) x_eff = x_in - H_LIM;
        if (y_in >= V_LIM) y_eff = y_in - V_LIM;
        write_ok = 1'b1;
`else
        write_ok = (x_in < H_LIM) && (y_in < V_LIM);
`endif
    end

    // y*160 as two shifts; ADDR_W holds 19199 without truncation.
    assign x_ext    = ADDR_W'(x_eff);
    assign y_ext    = ADDR_W'(y_eff);
    assign pix_addr = (y_ext << 7) + (y_ext << 5) + x_ext;
    assign nxt_cnt  = clr_cnt + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            fb_addr  <= '0;
            fb_data  <= '0;
            fb_wren  <= 1'b0;
            busy     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        fb_addr <= '0;
                        fb_data <= CLEAR_COLOUR;
                        fb_wren <= 1'b1;
                        busy    <= 1'b1;
                    end else if (accept && write_ok) begin
                        fb_addr <= pix_addr;
                        fb_data <= colour_in;
                        fb_wren <= 1'b1;
                    end else begin
                        fb_wren <= 1'b0;
                        if (accept && drop_cnt != 8'hFF)
                            drop_cnt <= drop_cnt + 8'd1;
                    end
                end
                CLEAR: begin
                    // clr_cnt mirrors the address currently on fb_addr.
                    if (clr_cnt == LAST_PIX) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                        fb_wren <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        clr_cnt <= nxt_cnt;
                        fb_addr <= nxt_cnt;
                        fb_data <= CLEAR_COLOUR;
                        fb_wren <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: directed and random stimulus against a
// behavioural frame-buffer writer model.
module tb_fb_pixel_writer;

    localparam int NPIX = 160 * 120;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [2:0]  colour_in;
    logic        plot_in;
    logic        ready_out;
    logic        clear_req;
    logic        busy;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_wren;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    fb_pixel_writer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .x_in      (x_in),
        .y_in      (y_in),
        .colour_in (colour_in),
        .plot_in   (plot_in),
        .ready_out (ready_out),
        .clear_req (clear_req),
        .busy      (busy),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_wren   (fb_wren),
        .drop_cnt  (drop_cnt)
    );

    int total  = 0;
    int passed = 0;

    // Model: sweep position (-1 = not sweeping) plus expected outputs.
    int m_pos  = -1;
    int m_wren = 0;
    int m_busy = 0;
    int m_addr = 0;
    int m_data = 0;
    int m_drop = 0;
    int wr_cnt = 0;
    int busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model(input bit rst, input int x, input int y,
                         input int c, input bit plot, input bit clr);
        int  xx;
        int  yy;
        bit  ok;
        xx = x;
        yy = y;
        if (!rst) begin
            m_pos  = -1;
            m_wren = 0;
            m_busy = 0;
            m_addr = 0;
            m_data = 0;
            m_drop = 0;
        end else if (m_pos >= 0) begin
            if (m_pos == NPIX - 1) begin
                m_pos  = -1;
                m_wren = 0;
                m_busy = 0;
            end else begin
                m_pos  = m_pos + 1;
                m_addr = m_pos;
            end
        end else if (clr) begin
            m_pos  = 0;
            m_wren = 1;
            m_busy = 1;
            m_addr = 0;
            m_data = 0;
        end else if (plot) begin
`ifdef FB_COORD_WRAP_EN
            if (xx >= 160) xx = xx - 160;
            if (yy >= 120) yy = yy - 120;
            ok = 1'b1;
`else
            ok = (xx < 160) && (yy < 120);
`endif
            if (ok) begin
                m_wren = 1;
                m_addr = yy * 160 + xx;
                m_data = c;
            end else begin
                m_wren = 0;
                if (m_drop < 255) m_drop = m_drop + 1;
            end
        end else begin
            m_wren = 0;
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit rst, input int x, input int y,
                        input int c, input bit plot, input bit clr);
        reset_n   = rst;
        x_in      = x[7:0];
        y_in      = y[6:0];
        colour_in = c[2:0];
        plot_in   = plot;
        clear_req = clr;
        #1;
        if (rst)
            chk("ready", 32'(ready_out), 32'(m_pos < 0 && !clr));
        @(posedge clk);
        model(rst, x, y, c, plot, clr);
        @(negedge clk);
        chk("wren", 32'(fb_wren), 32'(m_wren));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("addr", 32'(fb_addr), 32'(m_addr));
        chk("data", 32'(fb_data), 32'(m_data));
        chk("drop", 32'(drop_cnt), 32'(m_drop));
        if (fb_wren === 1'b1 && fb_data === 3'd0) wr_cnt++;
        if (busy === 1'b1) busy_cnt++;
    endtask

    int exp4[4] = '{0, 159, 19040, 19199};
    int xs4[4]  = '{0, 159, 0, 159};
    int ys4[4]  = '{0, 0, 119, 119};

    initial begin
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_wren", 32'(fb_wren), 0);
        chk("rst_addr", 32'(fb_addr), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        step(1, 3, 2, 5, 1, 0);
        chk("p323_addr", 32'(fb_addr), 323);
        chk("p323_data", 32'(fb_data), 5);
        chk("p323_wren", 32'(fb_wren), 1);
        step(1, 0, 0, 0, 0, 0);
        chk("p323_off", 32'(fb_wren), 0);

        for (int i = 0; i < 4; i++) begin
            step(1, xs4[i], ys4[i], i + 1, 1, 0);
            chk("corner_addr", 32'(fb_addr), 32'(exp4[i]));
            chk("corner_wren", 32'(fb_wren), 1);
        end
        step(1, 0, 0, 0, 0, 0);

        step(1, 160, 5, 2, 1, 0);
`ifdef FB_COORD_WRAP_EN
        chk("wrap_x", 32'(fb_addr), 800);
`else
        chk("drop_x", 32'(fb_wren), 0);
`endif
        step(1, 10, 120, 2, 1, 0);
`ifdef FB_COORD_WRAP_EN
        chk("wrap_y", 32'(fb_addr), 10);
        chk("drop2", 32'(drop_cnt), 0);
`else
        chk("drop_y", 32'(fb_wren), 0);
        chk("drop2", 32'(drop_cnt), 2);
`endif
        for (int i = 0; i < 300; i++)
            step(1, 200, 125, 1, 1, 0);
`ifdef FB_COORD_WRAP_EN
        chk("drop_sat", 32'(drop_cnt), 0);
`else
        chk("drop_sat", 32'(drop_cnt), 255);
`endif

        for (int i = 0; i < 300; i++)
            step(1, int'($urandom_range(0, 199)),
                 int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)),
                 bit'($urandom_range(0, 1)), 0);

        // Clear pulse with a plot held for the whole sweep.
        wr_cnt   = 0;
        busy_cnt = 0;
        step(1, 7, 9, 3, 0, 1);
        for (int i = 0; i < NPIX; i++)
            step(1, 7, 9, 3, 1, 0);
        chk("clr_writes", 32'(wr_cnt), 32'(NPIX));
        chk("clr_busy", 32'(busy_cnt), 32'(NPIX));
        step(1, 7, 9, 3, 1, 0);
        chk("held_addr", 32'(fb_addr), 1447);
        chk("held_data", 32'(fb_data), 3);
        step(1, 0, 0, 0, 0, 0);

        // Clear and plot together: plot waits for the sweep.
        step(1, 11, 4, 6, 1, 1);
        chk("clr_pri", 32'(fb_addr), 0);
        for (int i = 0; i < NPIX; i++)
            step(1, 11, 4, 6, 1, 0);
        step(1, 11, 4, 6, 1, 0);
        chk("late_addr", 32'(fb_addr), 651);
        chk("late_data", 32'(fb_data), 6);
        step(1, 0, 0, 0, 0, 0);

        // Reset in the middle of a sweep.
        step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5000; i++)
            step(1, 0, 0, 0, 0, 0);
        chk("mid_addr", 32'(fb_addr), 5000);
        step(0, 0, 0, 0, 0, 0);
        chk("mid_rst_wren", 32'(fb_wren), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        wr_cnt = 0;
        for (int i = 0; i < 20; i++)
            step(1, 0, 0, 0, 0, 0);
        chk("mid_no_wr", 32'(wr_cnt), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
